// File: rtl/bram_scanout_pkg.sv
// Shared definitions for blocks facing the 256x16 block RAM.
package bram_scanout_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/bit_period_strobe.sv
// Bit-period timer: counts CLOCKS_PER_BIT cycles and strobes on the last one.
module bit_period_strobe #(
  parameter int unsigned CLOCKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic strobe_o
);

  localparam int unsigned CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  // Next count: restart on clear or at the end of each period.
  always_comb begin
    at_last = (cnt_q == LAST);
    cnt_d   = cnt_q + 1'b1;
    if (clear_i || at_last) begin
      cnt_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe_o = at_last && !clear_i;

endmodule

// File: rtl/bram_scanout.sv
// Reads a run of words from a block RAM and shifts them out MSB first,
// prefetching the next word so consecutive words stream without gaps.
module bram_scanout
  import bram_scanout_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned CLOCKS_PER_BIT = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     read_enable,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     serial_out,
  output logic                     frame
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LSB_BIT = BW'(DATA_WIDTH - 1);
  // With one clock per bit the LSB period is a single cycle, too short to
  // read and capture in; the prefetch then moves one bit earlier and the
  // returning data is taken straight off read_data at the word boundary.
  localparam logic [BW-1:0] PF_BIT  = BW'((CLOCKS_PER_BIT == 1) ? DATA_WIDTH - 2 : DATA_WIDTH - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]    next_q, next_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic                     have_next_q, have_next_d;
  logic                     pf_valid_q, pf_valid_d;
  logic                     first_q, first_d;
  logic                     zdone_q, zdone_d;
  logic                     pf;
  logic                     strobe;
  logic [DATA_WIDTH-1:0]    load_word;

  bit_period_strobe #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_strobe (
    .clk_i   (CLK),
    .rst_i   (reset),
    .clear_i (state_q != ST_SHIFT),
    .strobe_o(strobe)
  );

  // Next-state, read control and shift datapath.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    next_d      = next_q;
    bit_d       = bit_q;
    have_next_d = have_next_q;
    zdone_d     = 1'b0;
    pf          = 1'b0;
    read_enable = 1'b0;
    load_word   = pf_valid_q ? read_data : next_q;
    if (pf_valid_q) begin
      next_d = read_data;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start && !zdone_q) begin
          if (word_count != '0) begin
            addr_d  = start_address;
            rem_d   = word_count;
            state_d = ST_FETCH;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        read_enable = 1'b1;
        addr_d      = addr_q + 1'b1;
        rem_d       = rem_q - 1'b1;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d     = read_data;
        bit_d       = '0;
        have_next_d = 1'b0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (first_q && (bit_q == PF_BIT) && (rem_q != '0) && !have_next_q) begin
          pf          = 1'b1;
          read_enable = 1'b1;
          addr_d      = addr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          have_next_d = 1'b1;
        end
        if (strobe) begin
          if (bit_q == LSB_BIT) begin
            if (have_next_q) begin
              shreg_d     = load_word;
              bit_d       = '0;
              have_next_d = 1'b0;
            end else begin
              state_d = ST_FINISH;
            end
          end else begin
            shreg_d = shreg_q << 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pf_valid_d = pf;
    first_d    = (state_d == ST_SHIFT) && ((state_q != ST_SHIFT) || strobe);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      shreg_q     <= '0;
      next_q      <= '0;
      bit_q       <= '0;
      have_next_q <= 1'b0;
      pf_valid_q  <= 1'b0;
      first_q     <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      next_q      <= next_d;
      bit_q       <= bit_d;
      have_next_q <= have_next_d;
      pf_valid_q  <= pf_valid_d;
      first_q     <= first_d;
      zdone_q     <= zdone_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH) || zdone_q;
  assign frame        = (state_q == ST_SHIFT);
  assign serial_out   = frame && shreg_q[DATA_WIDTH-1];
  assign read_address = addr_q;

endmodule

// File: tb/tb_bram_scanout.sv
// Bench for bram_scanout: one instance at 4 clocks/bit, one at 1 clock/bit,
// both reading a behavioural 1-cycle-latency RAM.
module tb_bram_scanout;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  saddr_a = '0, saddr_b = '0;
  logic [8:0]  wc_a = '0, wc_b = '0;
  logic        busy_a, done_a, re_a, ser_a, frame_a;
  logic        busy_b, done_b, re_b, ser_b, frame_b;
  logic [7:0]  raddr_a, raddr_b;
  logic [15:0] rdata_a = '0, rdata_b = '0;
  logic [15:0] mem [256];

  int          n_checks = 0;
  int          n_errors = 0;

  int          reads [2];
  int          frame_cyc [2];
  int          rises [2];
  int          first_frame [2];
  int          done_cnt [2];
  int          done_cyc [2];
  bit          busy_seen [2];
  bit          prev_frame [2];
  logic        smp0 [$];
  logic        smp1 [$];
  int          ra0 [$];
  int          ra1 [$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (re_a) rdata_a <= mem[raddr_a];
    if (re_b) rdata_b <= mem[raddr_b];
  end

  bram_scanout #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16), .CLOCKS_PER_BIT(4)) dut_a (
    .CLK(CLK), .reset(reset), .start(start_a), .start_address(saddr_a),
    .word_count(wc_a), .busy(busy_a), .done(done_a), .read_address(raddr_a),
    .read_enable(re_a), .read_data(rdata_a), .serial_out(ser_a), .frame(frame_a)
  );

  bram_scanout #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16), .CLOCKS_PER_BIT(1)) dut_b (
    .CLK(CLK), .reset(reset), .start(start_b), .start_address(saddr_b),
    .word_count(wc_b), .busy(busy_b), .done(done_b), .read_address(raddr_b),
    .read_enable(re_b), .read_data(rdata_b), .serial_out(ser_b), .frame(frame_b)
  );

  always @(negedge CLK) begin
    if (re_a) begin reads[0]++; ra0.push_back(int'(raddr_a)); end
    if (frame_a) begin
      frame_cyc[0]++;
      smp0.push_back(ser_a);
      if (!prev_frame[0]) begin
        if (rises[0] == 0) first_frame[0] = cyc;
        rises[0]++;
      end
    end
    prev_frame[0] = frame_a;
    if (done_a) begin done_cnt[0]++; done_cyc[0] = cyc; end
    if (busy_a) busy_seen[0] = 1'b1;
  end

  always @(negedge CLK) begin
    if (re_b) begin reads[1]++; ra1.push_back(int'(raddr_b)); end
    if (frame_b) begin
      frame_cyc[1]++;
      smp1.push_back(ser_b);
      if (!prev_frame[1]) begin
        if (rises[1] == 0) first_frame[1] = cyc;
        rises[1]++;
      end
    end
    prev_frame[1] = frame_b;
    if (done_b) begin done_cnt[1]++; done_cyc[1] = cyc; end
    if (busy_b) busy_seen[1] = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] sa, input logic [8:0] wc);
    if (sel == 0) begin start_a = s; saddr_a = sa; wc_a = wc; end
    else begin start_b = s; saddr_b = sa; wc_b = wc; end
  endtask

  task automatic clear_stats(input int sel);
    reads[sel] = 0; frame_cyc[sel] = 0; rises[sel] = 0; first_frame[sel] = 0;
    done_cnt[sel] = 0; done_cyc[sel] = 0; busy_seen[sel] = 1'b0;
    if (sel == 0) begin smp0.delete(); ra0.delete(); end
    else begin smp1.delete(); ra1.delete(); end
  endtask

  // Start a scan; t0 is the cycle count seen right after the start edge.
  // A nonzero poke re-pulses start (different address/count) mid-scan.
  task automatic run(input int sel, input logic [7:0] sa, input logic [8:0] wc,
                     input int poke, input int limit, output int t0);
    @(negedge CLK);
    clear_stats(sel);
    drive(sel, 1'b1, sa, wc);
    @(negedge CLK);
    drive(sel, 1'b0, sa, wc);
    t0 = cyc;
    for (int i = 1; i < limit; i++) begin
      @(negedge CLK);
      if (i == poke) drive(sel, 1'b1, ~sa, 9'd5);
      else drive(sel, 1'b0, sa, wc);
      #1;
      if (done_cnt[sel] != 0) break;
    end
    drive(sel, 1'b0, sa, wc);
    repeat (3) @(negedge CLK);
  endtask

  function automatic logic [15:0] word_at(input logic q[$], input int cpb, input int w);
    logic [15:0] r = '0;
    for (int k = 0; k < 16; k++) begin
      int idx = (w * 16 + k) * cpb;
      r[15-k] = (idx < q.size()) ? q[idx] : 1'b0;
    end
    return r;
  endfunction

  function automatic int hold_errs(input logic q[$], input int cpb);
    int e = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] !== q[(i / cpb) * cpb]) e++;
    end
    return e;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    int t0;
    int bad;
    int hits [256];
    logic [15:0] w;

    for (int i = 0; i < 256; i++) mem[i] = {~8'(i), 8'(i)};
    mem[8'h45] = 16'hA50F;
    mem[8'hFE] = 16'h1234;
    mem[8'hFF] = 16'hABCD;
    mem[8'h00] = 16'hF00F;
    mem[8'h20] = 16'h8001;
    mem[8'h21] = 16'h7FFE;
    clear_stats(0);
    clear_stats(1);

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_frame", frame_a, 0);
    check("rst_serial", ser_a, 0);
    check("rst_re", re_a, 0);
    check("rst_raddr", raddr_a, 0);
    reset = 1'b0;

    // Single word, 4 clocks/bit
    run(0, 8'h45, 9'd1, 0, 400, t0);
    check("t1_reads", reads[0], 1);
    check("t1_addr", ra0[0], 32'h45);
    check("t1_word", word_at(smp0, 4, 0), 16'hA50F);
    check("t1_hold", hold_errs(smp0, 4), 0);
    check("t1_frame_cycles", frame_cyc[0], 64);
    check("t1_frame_rises", rises[0], 1);
    check("t1_first_bit_lat", first_frame[0] - t0, 2);
    check("t1_done_cnt", done_cnt[0], 1);
    check("t1_done_lat", done_cyc[0] - t0, 66);
    check("t1_busy_end", busy_a, 0);

    // Three words across the address wrap
    run(0, 8'hFE, 9'd3, 0, 600, t0);
    check("t2_reads", reads[0], 3);
    check("t2_addr0", ra0[0], 32'hFE);
    check("t2_addr1", ra0[1], 32'hFF);
    check("t2_addr2", ra0[2], 32'h00);
    check("t2_word0", word_at(smp0, 4, 0), 16'h1234);
    check("t2_word1", word_at(smp0, 4, 1), 16'hABCD);
    check("t2_word2", word_at(smp0, 4, 2), 16'hF00F);
    check("t2_hold", hold_errs(smp0, 4), 0);
    check("t2_frame_cycles", frame_cyc[0], 192);
    check("t2_frame_rises", rises[0], 1);
    check("t2_done_cnt", done_cnt[0], 1);

    // Zero words; start held into the done cycle must be ignored
    @(negedge CLK);
    clear_stats(0);
    drive(0, 1'b1, 8'h10, 9'd0);
    @(negedge CLK);
    t0 = cyc;
    drive(0, 1'b1, 8'h45, 9'd1);
    @(negedge CLK);
    drive(0, 1'b0, 8'h45, 9'd1);
    repeat (20) @(negedge CLK);
    check("t3_reads", reads[0], 0);
    check("t3_done_cnt", done_cnt[0], 1);
    check("t3_done_lat", done_cyc[0] - t0, 0);
    check("t3_busy_seen", busy_seen[0], 0);
    check("t3_frame_cycles", frame_cyc[0], 0);

    // Start re-pulsed mid-scan is ignored
    run(0, 8'h20, 9'd2, 30, 600, t0);
    check("t4_reads", reads[0], 2);
    check("t4_addr1", ra0[1], 32'h21);
    check("t4_word0", word_at(smp0, 4, 0), 16'h8001);
    check("t4_word1", word_at(smp0, 4, 1), 16'h7FFE);
    check("t4_frame_cycles", frame_cyc[0], 128);
    check("t4_done_cnt", done_cnt[0], 1);

    // Reset during word 2 of 4
    @(negedge CLK);
    clear_stats(0);
    drive(0, 1'b1, 8'h30, 9'd4);
    @(negedge CLK);
    drive(0, 1'b0, 8'h30, 9'd4);
    repeat (80) @(negedge CLK);
    check("t5_pre_reads", reads[0], 2);
    check("t5_pre_frame", frame_a, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_frame_low", frame_a, 0);
    check("t5_busy_low", busy_a, 0);
    check("t5_re_low", re_a, 0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    check("t5_no_done", done_cnt[0], 0);
    run(0, 8'h45, 9'd1, 0, 400, t0);
    check("t5_fresh_word", word_at(smp0, 4, 0), 16'hA50F);
    check("t5_fresh_done", done_cnt[0], 1);

    // 256 words at 1 clock/bit from mid-memory
    run(1, 8'h80, 9'd256, 0, 6000, t0);
    check("t6_reads", reads[1], 256);
    for (int i = 0; i < 256; i++) hits[i] = 0;
    foreach (ra1[i]) hits[ra1[i] & 255]++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (hits[i] != 1) bad++;
    check("t6_addr_once", bad, 0);
    check("t6_frame_cycles", frame_cyc[1], 4096);
    check("t6_frame_rises", rises[1], 1);
    bad = 0;
    for (int wi = 0; wi < 256; wi++) begin
      w = word_at(smp1, 1, wi);
      if (w !== mem[(128 + wi) % 256]) bad++;
    end
    check("t6_stream_words", bad, 0);
    check("t6_done_cnt", done_cnt[1], 1);
    check("t6_done_lat", done_cyc[1] - t0, 4098);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
